// File: rtl/sysx_slave_port.sv
// sysx_slave_port: sysX v1 peripheral-side responder. Oversamples the master's bus
//   clock on iClock, captures one 32-bit word per frame from MOSI (LSB first) and
//   returns one 32-bit word per frame on MISO.
// Latency: bus edges are seen pSyncStages+1 iClock cycles after the pin changes.
//   oRxData/oRxValid appear the cycle after the 4th data fall is detected.
// Backpressure: the TX holding register accepts a word when oTxReady=1. RX words are
//   not backpressured: the core must take each one-cycle oRxValid pulse.
// Ports:
//   iClock/iReset         system clock, synchronous active-high reset
//   iBusClock/iBusSelect  master bus clock (idle high) and chip select
//   iBusMOSI              master-to-slave byte
//   oBusMISO/oBusMISOEnable  slave-to-master byte and its output enable
//   oBusInterrupt         sticky interrupt to the master
//   iTxData/iTxValid/oTxReady  word to return in the next addressed frame
//   oRxData/oRxValid      last received word and its one-cycle strobe
//   iIrqRequest           raise oBusInterrupt
//   oFrameActive/oTxUnderrun   frame status
module sysx_slave_port #(
  parameter logic [1:0]  pAddress    = 2'h0,
  parameter int          pIdleCycles = 16,
  parameter int          pSyncStages = 2,
  parameter logic [31:0] pEmptyWord  = 32'hFFFFFFFF
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [7:0]  iBusMOSI,
  output logic [7:0]  oBusMISO,
  output logic        oBusMISOEnable,
  output logic        oBusInterrupt,
  input  logic [31:0] iTxData,
  input  logic        iTxValid,
  output logic        oTxReady,
  output logic [31:0] oRxData,
  output logic        oRxValid,
  input  logic        iIrqRequest,
  output logic        oFrameActive,
  output logic        oTxUnderrun
);

  localparam logic [7:0] IDLE_TH = 8'(pIdleCycles);

  typedef enum logic [2:0] {S_WAIT, S_READY, S_ACTIVE, S_DONE, S_SKIP} state_t;

  state_t state, state_n;

  // MOSI travels through the same number of flops as the clock so the byte
  // seen at a detected fall is the byte that was on the pins at that fall.
  logic [pSyncStages-1:0]      clk_sync;
  logic [pSyncStages-1:0][1:0] sel_sync;
  logic [pSyncStages-1:0][7:0] mosi_sync;
  logic       clk_s, clk_prev, fall, bus_idle;
  logic [1:0] sel_s;
  logic [7:0] mosi_s;
  logic [7:0] idle_cnt;

  logic [2:0]  fall_cnt;
  logic [31:0] shift;
  logic [31:0] hold;
  logic        hold_vld;
  logic [23:0] rx_buf;
  logic        frame_start, active_fall, last_fall, tx_load;

  assign clk_s    = clk_sync[pSyncStages-1];
  assign sel_s    = sel_sync[pSyncStages-1];
  assign mosi_s   = mosi_sync[pSyncStages-1];
  assign fall     = clk_prev & ~clk_s;
  assign bus_idle = (idle_cnt >= IDLE_TH);
  assign tx_load  = iTxValid & ~hold_vld;

  assign oTxReady       = ~hold_vld;
  assign oFrameActive   = (state == S_ACTIVE);
  assign oBusMISOEnable = (state == S_ACTIVE);
  assign oBusMISO       = (state == S_ACTIVE) ? shift[7:0] : 8'h00;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      clk_sync  <= '1;
      sel_sync  <= '0;
      mosi_sync <= '0;
      clk_prev  <= 1'b1;
      idle_cnt  <= 8'd0;
    end else begin
      clk_sync  <= {clk_sync[pSyncStages-2:0], iBusClock};
      sel_sync  <= {sel_sync[pSyncStages-2:0], iBusSelect};
      mosi_sync <= {mosi_sync[pSyncStages-2:0], iBusMOSI};
      clk_prev  <= clk_s;
      if (!clk_s)
        idle_cnt <= 8'd0;
      else if (idle_cnt != 8'hFF)
        idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_comb begin
    state_n     = state;
    frame_start = 1'b0;
    active_fall = 1'b0;
    case (state)
      S_WAIT:  if (bus_idle) state_n = S_READY;
      S_READY: begin
        if (fall) begin
          if (sel_s == pAddress) begin
            state_n     = S_ACTIVE;
            frame_start = 1'b1;
          end else begin
            state_n = S_SKIP;
          end
        end
      end
      S_ACTIVE: begin
        // A long idle mid-frame means the master gave up; drop the partial word.
        if (bus_idle) begin
          state_n = S_READY;
        end else if (fall) begin
          active_fall = 1'b1;
          if (fall_cnt == 3'd3) state_n = S_DONE;
        end
      end
      S_DONE, S_SKIP: if (bus_idle) state_n = S_READY;
      default: state_n = S_WAIT;
    endcase
    last_fall = active_fall && (fall_cnt == 3'd3);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state         <= S_WAIT;
      fall_cnt      <= 3'd0;
      shift         <= 32'd0;
      hold          <= 32'd0;
      hold_vld      <= 1'b0;
      rx_buf        <= 24'd0;
      oRxData       <= 32'd0;
      oRxValid      <= 1'b0;
      oTxUnderrun   <= 1'b0;
      oBusInterrupt <= 1'b0;
    end else begin
      state       <= state_n;
      oRxValid    <= 1'b0;
      oTxUnderrun <= 1'b0;

      // Frame start releases the holding register; a same-cycle load refills it.
      if (frame_start) begin
        fall_cnt    <= 3'd0;
        shift       <= hold_vld ? hold : pEmptyWord;
        oTxUnderrun <= ~hold_vld;
        hold_vld    <= 1'b0;
      end
      if (tx_load) begin
        hold     <= iTxData;
        hold_vld <= 1'b1;
      end

      if (active_fall) begin
        if (fall_cnt != 3'd4) fall_cnt <= fall_cnt + 3'd1;
        shift <= {8'h00, shift[31:8]};
        case (fall_cnt)
          3'd0: rx_buf[7:0]   <= mosi_s;
          3'd1: rx_buf[15:8]  <= mosi_s;
          3'd2: rx_buf[23:16] <= mosi_s;
          3'd3: begin
            oRxData  <= {mosi_s, rx_buf};
            oRxValid <= 1'b1;
          end
          default: ;
        endcase
      end

      // Set wins over clear when both land in the same cycle.
      if (iIrqRequest)
        oBusInterrupt <= 1'b1;
      else if (last_fall)
        oBusInterrupt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sysx_slave_port.sv
module tb_sysx_slave_port;

  localparam int         SYNC = 2;
  localparam int         IDLE = 16;
  localparam int         HALF = 8;
  localparam logic [1:0] ADDR = 2'h0;

  logic        iClock = 1'b0, iReset = 1'b1;
  logic        iBusClock = 1'b1;
  logic [1:0]  iBusSelect = 2'h0;
  logic [7:0]  iBusMOSI = 8'h00;
  logic [31:0] iTxData = 32'h0;
  logic        iTxValid = 1'b0, iIrqRequest = 1'b0;
  logic [7:0]  oBusMISO;
  logic        oBusMISOEnable, oBusInterrupt, oTxReady, oRxValid, oFrameActive, oTxUnderrun;
  logic [31:0] oRxData;

  sysx_slave_port #(.pAddress(ADDR), .pIdleCycles(IDLE), .pSyncStages(SYNC),
                    .pEmptyWord(32'hFFFFFFFF)) dut (
    .iClock(iClock), .iReset(iReset), .iBusClock(iBusClock), .iBusSelect(iBusSelect),
    .iBusMOSI(iBusMOSI), .oBusMISO(oBusMISO), .oBusMISOEnable(oBusMISOEnable),
    .oBusInterrupt(oBusInterrupt), .iTxData(iTxData), .iTxValid(iTxValid),
    .oTxReady(oTxReady), .oRxData(oRxData), .oRxValid(oRxValid),
    .iIrqRequest(iIrqRequest), .oFrameActive(oFrameActive), .oTxUnderrun(oTxUnderrun));

  always #5 iClock = ~iClock;

  int vectors = 0, miscompares = 0;

  // Scoreboard queues filled by the stimulus side from the reference model.
  logic [7:0]  exp_miso[$];
  logic [31:0] exp_rx[$];
  int          exp_underrun = 0;

  // Reference model of the slave's externally visible state.
  bit          m_held_vld = 0;
  logic [31:0] m_held = 32'h0;
  bit          m_irq = 0;

  logic prev_bus_clk = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #2;
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oRxValid) begin
        if (exp_rx.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rx_unexpected: got %h, expected no word", oRxData);
        end else begin
          chk("rx_word", oRxData, exp_rx.pop_front());
        end
      end
      if (oTxUnderrun) begin
        vectors++;
        if (exp_underrun == 0) begin
          miscompares++;
          $display("FAIL underrun_unexpected: got pulse, expected none");
        end else begin
          exp_underrun--;
        end
      end
      // The master samples MISO at each fall it drives.
      if (prev_bus_clk && !iBusClock) begin
        if (oBusMISOEnable) begin
          if (exp_miso.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL miso_unexpected: got %h, expected MISO disabled", oBusMISO);
          end else begin
            chk("miso_byte", oBusMISO, exp_miso.pop_front());
          end
          chk("frame_active", oFrameActive, 1);
        end else begin
          chk("miso_idle", oBusMISO, 0);
        end
      end
    end
    prev_bus_clk <= iBusClock;
  end

  task automatic check_reset_vals();
    chk("rst_tx_ready", oTxReady, 1);
    chk("rst_rx_data", oRxData, 0);
    chk("rst_miso", oBusMISO, 0);
    chk("rst_miso_en", oBusMISOEnable, 0);
    chk("rst_rx_valid", oRxValid, 0);
    chk("rst_irq", oBusInterrupt, 0);
    chk("rst_frame_active", oFrameActive, 0);
    chk("rst_underrun", oTxUnderrun, 0);
  endtask

  task automatic load_tx(input logic [31:0] w);
    int t = 0;
    while (!oTxReady && t < 100) begin tick(); t++; end
    if (t >= 100) chk("tx_ready_timeout", oTxReady, 1);
    iTxData = w; iTxValid = 1'b1;
    tick();
    iTxValid = 1'b0;
    m_held = w; m_held_vld = 1;
    chk("tx_ready_drop", oTxReady, 0);
  endtask

  task automatic irq_pulse();
    iIrqRequest = 1'b1;
    tick();
    iIrqRequest = 1'b0;
    m_irq = 1;
    tick();
    chk("irq_set", oBusInterrupt, m_irq);
  endtask

  // One master frame: nfalls falls (fall 0 = load phase); optional reset after
  // fall rst_at; optional irq request landing on the slave's view of fall 4.
  task automatic run_frame(input logic [1:0] sel, input logic [39:0] mb,
                           input int nfalls, input int rst_at, input bit irq4);
    bit addr = (sel == ADDR);
    bit alive = 1;
    logic [31:0] word = 32'h0;
    iBusSelect = sel;
    for (int k = 0; k < nfalls; k++) begin
      iBusMOSI = mb[8*k +: 8];
      repeat (HALF) tick();
      if (alive && addr) begin
        if (k == 0) begin
          word = m_held_vld ? m_held : 32'hFFFFFFFF;
          if (!m_held_vld) exp_underrun++;
          m_held_vld = 0;
        end else begin
          exp_miso.push_back(word[8*(k-1) +: 8]);
          if (k == 4) begin
            exp_rx.push_back(mb[39:8]);
            m_irq = irq4;
          end
        end
      end
      iBusClock = 1'b0;
      for (int i = 0; i < HALF; i++) begin
        tick();
        iIrqRequest = (irq4 && k == 4 && i == SYNC - 1);
      end
      iIrqRequest = 1'b0;
      if (k == 0 && alive && addr) chk("tx_ready_after_start", oTxReady, !m_held_vld);
      if (k == rst_at) begin
        iReset = 1'b1;
        tick(); tick();
        check_reset_vals();
        iReset = 1'b0;
        m_held_vld = 0; m_irq = 0; alive = 0;
        tick();
      end
      iBusClock = 1'b1;
    end
    iBusMOSI = 8'h00;
    repeat (HALF + IDLE + 6) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1;
    repeat (3) tick();
    check_reset_vals();
    iReset = 1'b0;
    repeat (IDLE + 8) tick();

    // Basic addressed frame.
    load_tx(32'hCAFEF00D);
    run_frame(2'h0, 40'h44_33_22_11_00, 5, -1, 0);

    // Skipped frame keeps the held word for the next addressed frame.
    load_tx(32'h1234_5678);
    run_frame(2'h1, {$urandom(), 8'($urandom())}, 5, -1, 0);
    chk("tx_held_after_skip", oTxReady, !m_held_vld);
    run_frame(2'h0, {$urandom(), 8'($urandom())}, 5, -1, 0);

    // Underrun: nothing held.
    run_frame(2'h0, {$urandom(), 8'($urandom())}, 5, -1, 0);

    // Interrupt: sticky across a skip, cleared at fall 4, set wins on collision.
    irq_pulse();
    run_frame(2'h2, {$urandom(), 8'($urandom())}, 5, -1, 0);
    chk("irq_after_skip", oBusInterrupt, m_irq);
    run_frame(2'h0, {$urandom(), 8'($urandom())}, 5, -1, 0);
    chk("irq_cleared", oBusInterrupt, m_irq);
    irq_pulse();
    run_frame(2'h0, {$urandom(), 8'($urandom())}, 5, -1, 1);
    chk("irq_set_wins", oBusInterrupt, m_irq);
    run_frame(2'h0, {$urandom(), 8'($urandom())}, 5, -1, 0);
    chk("irq_cleared_again", oBusInterrupt, m_irq);

    // Abort after fall 2, then a full frame.
    run_frame(2'h0, {$urandom(), 8'($urandom())}, 3, -1, 0);
    run_frame(2'h0, 40'hDD_CC_BB_AA_00, 5, -1, 0);

    // Reset mid-frame, then a fresh frame.
    irq_pulse();
    run_frame(2'h0, {$urandom(), 8'($urandom())}, 5, 2, 0);
    load_tx(32'hA5A5_0F0F);
    run_frame(2'h0, 40'h88_77_66_55_00, 5, -1, 0);

    // Randomised frames.
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(1) == 1 && !m_held_vld) load_tx($urandom());
      if ($urandom_range(3) == 0) irq_pulse();
      run_frame(2'($urandom_range(3)), {$urandom(), 8'($urandom())}, 5, -1, 0);
      chk("irq_random", oBusInterrupt, m_irq);
      chk("tx_ready_random", oTxReady, !m_held_vld);
    end

    repeat (10) tick();
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("miso_queue_drained", exp_miso.size(), 0);
    chk("underrun_drained", exp_underrun, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysx_slave_port.md
Name: sysx_slave_port

Overview:
- sysX version 1 peripheral-side responder; the other end of the byte-parallel sysX bus from the master controller.
- Oversamples the master's bus clock on the local system clock and decodes one 32-bit word per frame from MOSI, least-significant byte first.
- Returns one 32-bit word per frame on MISO, raises the shared bus interrupt, and presents a simple valid/ready word interface to the peripheral core.

Parameters:
- pAddress, 2'h0: chip-select value this slave answers to.
- pIdleCycles, 16: consecutive iClock cycles of synchronised bus clock high that mark the bus idle (range 4..255).
- pSyncStages, 2: synchroniser depth for iBusClock and iBusSelect (2 or 3).
- pEmptyWord, 32'hFFFFFFFF: MISO word sent when no TX word is pending.

Ports:
- iClock  in  1  system clock; must run at ≥ 8x the bus-clock frequency.
- iReset  in  1  synchronous, active-high reset.
- iBusClock  in  1  master bus clock; idle high.
- iBusSelect  in  2  master chip select.
- iBusMOSI  in  8  master-to-slave byte.
- oBusMISO  out  8  slave-to-master byte.
- oBusMISOEnable  out  1  MISO output enable; MISO is driven only when this is 1.
- oBusInterrupt  out  1  active-high interrupt to the master.
- iTxData  in  32  word to return in the next frame.
- iTxValid  in  1  iTxData valid.
- oTxReady  out  1  TX holding register empty.
- oRxData  out  32  last received word.
- oRxValid  out  1  one-cycle pulse; oRxData is new.
- iIrqRequest  in  1  one-cycle request to raise the interrupt.
- oFrameActive  out  1  an addressed frame is in progress.
- oTxUnderrun  out  1  one-cycle pulse when a frame starts with no TX word held.

Behaviour:

Synchronisation:
- iBusClock and iBusSelect pass through pSyncStages flops; iBusMOSI is sampled from the same stage as the clock.
- Fall = sync clock 1→0 between consecutive cycles. Rise = sync clock 0→1.
- Idle counter: increments (saturating) while sync clock is high; clears to 0 when it is low. busIdle = (count ≥ pIdleCycles).

FSM states:
- sWait: ignore edges until busIdle, then go to sReady.
- sReady: on Fall, sample select.
  - select == pAddress: go to sActive, set fall count = 0, copy TX holding register into shift register. If nothing is held, load pEmptyWord and pulse oTxUnderrun.
  - select != pAddress: go to sSkip.
- sActive: each Fall increments the fall count.
  - Falls 1..4 capture the MOSI byte into rx[7:0], [15:8], [23:16], [31:24] respectively.
  - At Fall 4: oRxData updates and oRxValid pulses 1 cycle later; go to sDone.
  - busIdle before Fall 4 aborts the frame: no oRxValid, go to sReady.
- sDone / sSkip: when busIdle, go to sReady. Extra Falls are ignored.

Frame start:
- Fall 0 is the master's load phase; its MOSI byte is discarded.

MISO:
- After Fall n (n = 0..3), oBusMISO = shift byte n; it is held until Fall n+1, where the master samples it.
- oBusMISOEnable = 1 only in sActive. MISO = 8'h00 when not enabled.

oFrameActive:
- 1 in sActive only.

TX handshake:
- Load occurs on iTxValid && oTxReady. oTxReady drops the next cycle.
- oTxReady returns the cycle after the holding register is copied at frame start.
- A held word survives skipped and aborted frames.

Interrupt:
- iIrqRequest sets oBusInterrupt, which is sticky.
- Cleared at the Fall 4 of an addressed frame.
- A set and a clear in the same cycle leave it set.

Reset values:
- FSM = sWait; idle counter = 0; holding register empty.
- oTxReady = 1; oRxData = 0; oBusMISO = 0; oBusMISOEnable = 0.
- oRxValid, oBusInterrupt, oFrameActive, oTxUnderrun = 0.
- Reset mid-frame discards the partial word. A new frame is accepted only after a fresh idle period.

Widths:
- Fall count is 3 bits and saturates at 4.

Test Plan:
1. Load iTxData=32'hCAFEF00D; master frame with pAddress=0, MOSI bytes 0x00,0x11,0x22,0x33,0x44 -> oRxData=32'h44332211 with a single oRxValid pulse; MISO bytes in order 0x0D,0xF0,0xFE,0xCA; oTxReady=1 after Fall 0.
2. Frame with select=2'h1 while pAddress=0 -> oBusMISOEnable stays 0, no oRxValid, held TX word still delivered in the next frame addressed to 0.
3. Frame with no TX word loaded -> oTxUnderrun pulses once, MISO returns 0xFF x4, oRxValid still pulses.
4. iIrqRequest pulse -> oBusInterrupt=1; stays 1 across a skipped frame; cleared at Fall 4 of an addressed frame; request coincident with Fall 4 -> stays 1.
5. Bus clock held high for pIdleCycles after Fall 2 -> no oRxValid, FSM returns to sReady; next full frame with bytes 0xAA..0xDD -> oRxData=32'hDDCCBBAA.
6. iReset asserted after Fall 2 -> all outputs at reset values; remaining edges of that frame ignored; the following frame after an idle period is received correctly.
